ctrl_mc: RTL and testbench



---
 rtl/ctrl_mc.sv | 166 ++++++++++++++++
 tb/tb_ctrl_mc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle RV32I control FSM with memory-ready stalls, extended branches and sticky illegal trap
module ctrl_mc #(
    parameter bit EXT_BRANCH    = 1'b1,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_B  = 7'b1100011;

    state_t     state_q, state_d;
    logic       ill_q;
    logic       ready, br_ok, taken;
    logic       pc_w, ir_w, mem_w, reg_w;
    logic [1:0] alu_op, imm;
    logic [2:0] alu_dec;

    assign ready   = USE_MEM_READY ? MemReady : 1'b1;
    assign br_ok   = EXT_BRANCH ? (funct3[2:1] != 2'b01) : (funct3 == 3'b000);
    assign taken   = funct3[2] ? ((funct3[1] ? Ltu : Lt) ^ funct3[0]) : (Zero ^ funct3[0]);
    assign alu_dec = (funct3 == 3'b000) ? {2'b00, op[5] & funct7} :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;
    assign imm     = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : (op == OP_J) ? 2'b11 : 2'b00;

    assign ALUControl = (alu_op == 2'b10) ? alu_dec : (alu_op == 2'b01) ? 3'b001 : 3'b000;
    assign ImmSrc     = (state_q == TRAP) ? 2'b00 : imm;
    assign Illegal    = ill_q;
    assign State      = state_q;

    // Write enables are held low for as long as reset is asserted
    assign PCWrite  = pc_w & rst_n;
    assign IRWrite  = ir_w & rst_n;
    assign MemWrite = mem_w & rst_n;
    assign RegWrite = reg_w & rst_n;

    // Moore output decode and next-state selection
    always_comb begin
        state_d   = state_q;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_w      = ready;
                ir_w      = ready;
                state_d   = ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_R)           ? EXECR :
                          (op == OP_I)           ? EXECI :
                          (op == OP_J)           ? JAL :
                          (op == OP_B && br_ok)  ? BRANCH : TRAP;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_w    = 1'b1;
                state_d = ALUWB;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                pc_w    = taken;
                state_d = FETCH;
            end
            default: state_d = TRAP;
        endcase
    end

    // State register and sticky trap flag; only reset leaves TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_q | (state_d == TRAP);
        end
    end
endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: table-driven cycle vectors plus hand sequences for trap, async reset and beq-only builds
module tb_ctrl_mc;
    localparam int R = 51, I = 19, LW = 3, SW = 35, B = 99, J = 111, BAD = 127;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, mr;
        logic [20:0] exp;
    } vec_t;

    logic       clk, rst_n, rst0_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7, Zero, Lt, Ltu, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0, Illegal0;
    logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0;
    logic [2:0] ALUControl0;
    logic [3:0] State0;
    int checks = 0, failures = 0;
    vec_t tbl[$];

    ctrl_mc dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    ctrl_mc #(.EXT_BRANCH(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
        .RegWrite(RegWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ImmSrc(ImmSrc0), .ALUControl(ALUControl0), .Illegal(Illegal0), .State(State0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int o, f3, f7, z, lt, mr, st, pcw, irw, rw, mw, adr, res, a, b, alu, imm, ill);
        vec_t v;
        v.op  = 7'(o);
        v.f3  = 3'(f3);
        v.f7  = 1'(f7);
        v.z   = 1'(z);
        v.lt  = 1'(lt);
        v.mr  = 1'(mr);
        v.exp = {4'(st), 1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(adr), 2'(res), 2'(a), 2'(b), 3'(alu), 2'(imm), 1'(ill)};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // op,f3,f7,z,lt,mr | st,pcw,irw,rw,mw,adr,res,a,b,alu,imm,ill
        tbl.push_back(mk(R,0,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(R,0,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(R,0,0,0,0,1,  6,0,0,0,0,0,0,2,0,0,0,0));
        tbl.push_back(mk(R,0,0,0,0,1,  7,0,0,1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(R,0,1,0,0,1,  0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(R,0,1,0,0,1,  1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(R,0,1,0,0,1,  6,0,0,0,0,0,0,2,0,1,0,0));
        tbl.push_back(mk(R,0,1,0,0,1,  7,0,0,1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(R,2,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(R,2,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(R,2,0,0,0,1,  6,0,0,0,0,0,0,2,0,5,0,0));
        tbl.push_back(mk(R,2,0,0,0,1,  7,0,0,1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(I,0,1,0,0,1,  0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(I,0,1,0,0,1,  1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(I,0,1,0,0,1,  8,0,0,0,0,0,0,2,1,0,0,0));
        tbl.push_back(mk(I,0,1,0,0,1,  7,0,0,1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(I,6,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(I,6,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(I,6,0,0,0,1,  8,0,0,0,0,0,0,2,1,3,0,0));
        tbl.push_back(mk(I,6,0,0,0,1,  7,0,0,1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,1, 0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,1, 1,0,0,0,0,0,0,1,1,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,1, 2,0,0,0,0,0,0,2,1,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,0, 3,0,0,0,0,1,0,0,0,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,0, 3,0,0,0,0,1,0,0,0,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,1, 3,0,0,0,0,1,0,0,0,0,0,0));
        tbl.push_back(mk(LW,2,0,0,0,1, 4,0,0,1,0,0,1,0,0,0,0,0));
        tbl.push_back(mk(SW,2,0,0,0,1, 0,1,1,0,0,0,2,0,2,0,1,0));
        tbl.push_back(mk(SW,2,0,0,0,1, 1,0,0,0,0,0,0,1,1,0,1,0));
        tbl.push_back(mk(SW,2,0,0,0,1, 2,0,0,0,0,0,0,2,1,0,1,0));
        tbl.push_back(mk(SW,2,0,0,0,0, 5,0,0,0,1,1,0,0,0,0,1,0));
        tbl.push_back(mk(SW,2,0,0,0,1, 5,0,0,0,1,1,0,0,0,0,1,0));
        tbl.push_back(mk(B,0,0,1,0,0,  0,0,0,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,0,0,1,0,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,0,0,1,0,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,0,0,1,0,1, 10,1,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(B,0,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,0,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,0,0,0,0,0, 10,0,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(B,1,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,1,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,1,0,0,0,1, 10,1,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(B,1,0,1,0,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,1,0,1,0,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,1,0,1,0,1, 10,0,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(B,4,0,0,1,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,4,0,0,1,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,4,0,0,1,1, 10,1,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(B,4,0,1,0,1,  0,1,1,0,0,0,2,0,2,0,2,0));
        tbl.push_back(mk(B,4,0,1,0,1,  1,0,0,0,0,0,0,1,1,0,2,0));
        tbl.push_back(mk(B,4,0,1,0,1, 10,0,0,0,0,0,0,2,0,1,2,0));
        tbl.push_back(mk(J,0,0,0,0,1,  0,1,1,0,0,0,2,0,2,0,3,0));
        tbl.push_back(mk(J,0,0,0,0,1,  1,0,0,0,0,0,0,1,1,0,3,0));
        tbl.push_back(mk(J,0,0,0,0,1,  9,1,0,0,0,0,0,1,2,0,3,0));
        tbl.push_back(mk(J,0,0,0,0,1,  7,0,0,1,0,0,0,0,0,0,3,0));
        tbl.push_back(mk(BAD,0,0,0,0,1, 0,1,1,0,0,0,2,0,2,0,0,0));
        tbl.push_back(mk(BAD,0,0,0,0,1, 1,0,0,0,0,0,0,1,1,0,0,0));

        rst_n = 1'b0; rst0_n = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b1;
        #2;
        chk("reset", {State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
        chk("reset_ext0", {State0, Illegal0, PCWrite0, IRWrite0, RegWrite0, MemWrite0}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            op = tbl[k].op; funct3 = tbl[k].f3; funct7 = tbl[k].f7;
            Zero = tbl[k].z; Lt = tbl[k].lt; MemReady = tbl[k].mr;
            @(negedge clk);
            chk($sformatf("vec%0d", k),
                {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal},
                {11'd0, tbl[k].exp});
            step();
        end

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("trap%0d", k), {State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite}, {4'd11, 1'b1, 4'b0});
            step();
        end

        #2 rst_n = 1'b0;
        #1 chk("trap_async_rst", {State, Illegal}, 32'h0);
        step();
        rst_n = 1'b1;
        op = 7'(LW); funct3 = 3'd2; funct7 = 1'b0; MemReady = 1'b1;
        step();
        step();
        step();
        MemReady = 1'b0;
        #1 chk("lw_memread", {State, AdrSrc}, {4'd3, 1'b1});
        #1 MemReady = 1'b1;
        rst_n = 1'b0;
        #1 chk("lw_async_rst", {State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
        step();
        chk("rst_held", {State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_fetch", {State, PCWrite, IRWrite}, {4'd0, 2'b11});
        step();
        chk("rst_release_decode", State, 4'd1);

        rst0_n = 1'b1;
        op = 7'(B); funct3 = 3'd0; Zero = 1'b1; MemReady = 1'b1;
        @(negedge clk);
        chk("ext0_fetch", State0, 4'd0);
        step();
        step();
        @(negedge clk);
        chk("ext0_beq", {State0, PCWrite0}, {4'd10, 1'b1});
        step();
        funct3 = 3'd1; Zero = 1'b0;
        step();
        @(negedge clk);
        chk("ext0_bne_decode", State0, 4'd1);
        step();
        @(negedge clk);
        chk("ext0_bne_trap", {State0, Illegal0, PCWrite0}, {4'd11, 1'b1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
